matrix_op_seq: RTL and testbench

//  Sequential, runtime-selectable matrix engine for size x size matrices of unsigned length-bit elements.
//  Ops: add, subtract, transpose, multiply; one element (or one MAC) per clock.

---
 rtl/matrix_op_seq.sv | 194 +++++++++++++++++++
 tb/tb_matrix_op_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_op_seq.sv
// Sequential matrix engine: add, sub, transpose, multiply on size x size
// matrices of unsigned length-bit elements, one element or one MAC per clock.
// Ports: clk, rst_n (async low), start/op/first/second in;
//        busy, done (pulse), result (registered), sat (sticky) out.
// Build option: define MATRIX_OP_SAT_EN for unsigned saturating arithmetic.
module matrix_op_seq #(
    parameter int size   = 3,
    parameter int length = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [1:0]                    op,
    input  logic [size*size*length-1:0]   first,
    input  logic [size*size*length-1:0]   second,
    output logic                          busy,
    output logic                          done,
    output logic [size*size*length-1:0]  result,
    output logic                          sat
);

    localparam int W  = size * size * length;
    localparam int AW = 2 * length + $clog2(size);
    localparam int CW = (size > 1) ? $clog2(size) : 1;
    localparam logic [CW-1:0] LAST = CW'(size - 1);
    localparam logic [AW-1:0] MAXV = AW'({length{1'b1}});

`ifdef MATRIX_OP_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0]      op_q, op_d;
    logic [CW-1:0]   r_q, r_d, c_q, c_d, k_q, k_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            busy_q, busy_d, done_q, done_d, sat_q, sat_d;

    int              idx, tdx, adx, bdx;
    logic [length-1:0]   ea, eb, et, ma, mb, elem;
    logic [length:0]     sum, diff;
    logic [2*length-1:0] prod;
    logic [AW-1:0]       acc_n;
    logic                wr;

    // idx: element being produced; tdx: its transposed source;
    // adx/bdx: A(r,k) and B(k,c) for the current MAC step
    assign idx = int'(r_q) * size + int'(c_q);
    assign tdx = int'(c_q) * size + int'(r_q);
    assign adx = int'(r_q) * size + int'(k_q);
    assign bdx = int'(k_q) * size + int'(c_q);

    assign ea = a_q[idx*length +: length];
    assign eb = b_q[idx*length +: length];
    assign et = a_q[tdx*length +: length];
    assign ma = a_q[adx*length +: length];
    assign mb = b_q[bdx*length +: length];

    // Extra top bit holds carry (add) or borrow (sub)
    assign sum   = {1'b0, ea} + {1'b0, eb};
    assign diff  = {1'b0, ea} - {1'b0, eb};
    assign prod  = {{length{1'b0}}, ma} * {{length{1'b0}}, mb};
    assign acc_n = acc_q + AW'(prod);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        r_d     = r_q;
        c_d     = c_q;
        k_d     = k_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sat_d   = sat_q;
        elem    = '0;
        wr      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = first;
                    b_d     = second;
                    op_d    = op;
                    sat_d   = 1'b0;
                    busy_d  = 1'b1;
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            RUN: begin
                unique case (op_q)
                    2'd0: begin
                        wr   = 1'b1;
                        elem = sum[length-1:0];
                        if (SAT && sum[length]) begin
                            elem  = '1;
                            sat_d = 1'b1;
                        end
                    end
                    2'd1: begin
                        wr   = 1'b1;
                        elem = diff[length-1:0];
                        if (SAT && diff[length]) begin
                            elem  = '0;
                            sat_d = 1'b1;
                        end
                    end
                    2'd2: begin
                        wr   = 1'b1;
                        elem = et;
                    end
                    default: begin
                        // Element is written on its last MAC; acc restarts
                        if (k_q == LAST) begin
                            wr    = 1'b1;
                            elem  = acc_n[length-1:0];
                            acc_d = '0;
                            k_d   = '0;
                            if (SAT && (acc_n > MAXV)) begin
                                elem  = '1;
                                sat_d = 1'b1;
                            end
                        end else begin
                            acc_d = acc_n;
                            k_d   = k_q + 1'b1;
                        end
                    end
                endcase
                if (wr) begin
                    res_d[idx*length +: length] = elem;
                    if (c_q == LAST) begin
                        c_d = '0;
                        if (r_q == LAST) begin
                            r_d     = '0;
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = res_q;
    assign sat    = sat_q;

endmodule

// File: tb/tb_matrix_op_seq.sv
// Self-checking bench for matrix_op_seq: vector table + scoreboard on a
// 2x2 instance, hand sequences for hold/reset/back-to-back, 3x3 instance.
module tb_matrix_op_seq;

    localparam int S  = 2;
    localparam int L  = 8;
    localparam int N  = S * S;
    localparam int W  = N * L;
    localparam int S3 = 3;
    localparam int W3 = S3 * S3 * L;

`ifdef MATRIX_OP_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'd0;
    logic [W-1:0]  first = '0;
    logic [W-1:0]  second = '0;
    logic          busy, done, sat;
    logic [W-1:0]  result;

    logic          start3 = 1'b0;
    logic [1:0]    op3 = 2'd0;
    logic [W3-1:0] first3 = '0;
    logic [W3-1:0] second3 = '0;
    logic          busy3, done3, sat3;
    logic [W3-1:0] result3;

    matrix_op_seq #(.size(S), .length(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .first(first), .second(second), .busy(busy), .done(done),
        .result(result), .sat(sat)
    );

    matrix_op_seq #(.size(S3), .length(L)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .op(op3),
        .first(first3), .second(second3), .busy(busy3), .done(done3),
        .result(result3), .sat(sat3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] rw;
        logic         sw;
        logic [W-1:0] rs;
        logic         ss;
        logic [7:0]   lat;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] res;
        logic         sat;
        logic [7:0]   lat;
    } exp_t;

    vec_t tv[8];
    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   acc_cyc = 0;

    function automatic logic [W-1:0] pk(input logic [7:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    function automatic vec_t mk(input logic [1:0] o,
                                input logic [W-1:0] a, b, rw,
                                input logic sw,
                                input logic [W-1:0] rs,
                                input logic ss,
                                input logic [7:0] lat);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.rw = rw; v.sw = sw;
        v.rs = rs; v.ss = ss; v.lat = lat;
        return v;
    endfunction

    function automatic exp_t expect_of(input vec_t v);
        exp_t e;
        e.res = SAT ? v.rs : v.rw;
        e.sat = SAT ? v.ss : v.sw;
        e.lat = v.lat;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [W3-1:0] act, input logic [W3-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: every done pops one expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending job (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result, mon_e.res);
                chk("sat", sat, mon_e.sat);
                chk("latency", cyc - acc_cyc, mon_e.lat);
                chk("busy_at_done", busy, 1'b0);
            end
        end
    end

    task automatic wait_done(input int lim);
        bit seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no done expected done within %0d cycles", lim);
        end else begin
            @(negedge clk);
            chk("done_pulse", done, 1'b0);
        end
    endtask

    task automatic run(input vec_t v);
        @(negedge clk);
        op = v.op; first = v.a; second = v.b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first = '1;
        second = '1;
        chk("busy_after_accept", busy, 1'b1);
        acc_cyc = cyc;
        sb.push_back(expect_of(v));
        wait_done(40);
    endtask

    task automatic run3(input logic [1:0] o, input logic [W3-1:0] a, b,
                        input logic [W3-1:0] er, input int lat, input string nm);
        int k0;
        bit seen = 1'b0;
        @(negedge clk);
        op3 = o; first3 = a; second3 = b; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        first3 = '0;
        k0 = cyc;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (done3) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done", nm);
        end else begin
            chk({nm, "_result"}, result3, er);
            chk({nm, "_latency"}, cyc - k0, lat);
            chk({nm, "_sat"}, sat3, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W3-1:0] a3, id3, tr3;
        exp_t e1;

        tv[0] = mk(2'd0, pk(1, 2, 3, 4), pk(10, 20, 30, 40),
                   pk(11, 22, 33, 44), 1'b0, pk(11, 22, 33, 44), 1'b0, 8'd4);
        tv[1] = mk(2'd1, pk(5, 9, 7, 0), pk(7, 3, 7, 1),
                   pk(8'hFE, 6, 0, 8'hFF), 1'b0, pk(0, 6, 0, 0), 1'b1, 8'd4);
        tv[2] = mk(2'd0, pk(200, 255, 0, 128), pk(100, 1, 0, 128),
                   pk(44, 0, 0, 0), 1'b0, pk(255, 255, 0, 255), 1'b1, 8'd4);
        tv[3] = mk(2'd2, pk(1, 2, 3, 4), pk(99, 98, 97, 96),
                   pk(1, 3, 2, 4), 1'b0, pk(1, 3, 2, 4), 1'b0, 8'd4);
        tv[4] = mk(2'd3, pk(1, 2, 3, 4), pk(5, 6, 7, 8),
                   pk(19, 22, 43, 50), 1'b0, pk(19, 22, 43, 50), 1'b0, 8'd8);
        tv[5] = mk(2'd3, pk(16, 16, 1, 0), pk(16, 0, 16, 0),
                   pk(0, 0, 16, 0), 1'b0, pk(255, 0, 16, 0), 1'b1, 8'd8);
        tv[6] = mk(2'd1, pk(50, 60, 70, 80), pk(10, 20, 30, 80),
                   pk(40, 40, 40, 0), 1'b0, pk(40, 40, 40, 0), 1'b0, 8'd4);
        tv[7] = mk(2'd3, pk(255, 255, 255, 255), pk(255, 255, 255, 255),
                   pk(2, 2, 2, 2), 1'b0, pk(255, 255, 255, 255), 1'b1, 8'd8);

        #12;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_result", result, '0);
        chk("reset_sat", sat, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run(tv[i]);

        // start held through the job: no second accept until after done
        e1 = expect_of(tv[0]);
        @(negedge clk);
        op = tv[0].op; first = tv[0].a; second = tv[0].b; start = 1'b1;
        @(negedge clk);
        chk("hold_accept", busy, 1'b1);
        acc_cyc = cyc;
        sb.push_back(e1);
        for (int i = 0; i < 20 && !done; i++) begin
            chk("hold_busy", busy, 1'b1);
            @(negedge clk);
        end
        chk("hold_done_seen", done, 1'b1);
        sb.push_back(e1);
        @(negedge clk);
        chk("reaccept_after_done", busy, 1'b1);
        acc_cyc = cyc;
        start = 1'b0;
        wait_done(20);
        @(negedge clk);
        chk("idle_after_release", busy, 1'b0);

        // async reset two cycles into a multiply
        @(negedge clk);
        op = 2'd3; first = tv[4].a; second = tv[4].b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_result", result, '0);
        chk("abort_sat", sat, 1'b0);
        @(negedge clk);
        chk("abort_no_done", done, 1'b0);
        rst_n = 1'b1;
        run(tv[4]);

        // 3x3 transpose and multiply by identity
        for (int i = 0; i < 9; i++) begin
            a3[i*L +: L]  = 8'(i + 1);
            id3[i*L +: L] = (i % 4 == 0) ? 8'd1 : 8'd0;
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                tr3[(r*3+c)*L +: L] = 8'(c * 3 + r + 1);
        run3(2'd2, a3, id3, tr3, 9, "t3");
        run3(2'd3, a3, id3, a3, 27, "m3");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
